// File: rtl/pipe_csel_adder.sv
//
// pipe_csel_adder -- parametrised, pipelined carry-select adder/subtractor
// with valid/ready flow control on both sides.
//
// Optional feature macro: PIPE_CSEL_ADDER_SATURATE_EN
//   defined     : the final stage clamps sum to max positive / max negative
//                 (chosen by the sign of A) when signed overflow occurs;
//                 cout and of still come from the raw addition.
//   not defined : sum is always the wrapped (modulo 2^WIDTH) result.
//
// Parameters:
//   WIDTH  : operand/result width, >= 8
//   SEG_W  : carry-select segment width, must divide WIDTH
//   STAGES : pipeline register stages, must divide WIDTH/SEG_W
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake
//   A, B, cin, sub      : operands; sub=1 computes A + ~B + 1 (cin ignored)
//   out_valid/out_ready : result beat handshake
//   sum, cout, of       : result, raw carry out of MSB, signed overflow
//
// The last stage's register is the output register, so a beat accepted in
// cycle c is presented in cycle c+STAGES and the pipeline holds STAGES beats.

module pipe_csel_adder #(
    parameter int WIDTH  = 32,
    parameter int SEG_W  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int SPS  = NSEG / STAGES;   // segments resolved per stage

    // Stage-k inputs: operand A, prepared operand Bx, bits resolved so far,
    // and the carry into the first segment stage k resolves.
    logic [WIDTH-1:0] w_a  [STAGES];
    logic [WIDTH-1:0] w_b  [STAGES];
    logic [WIDTH-1:0] w_lo [STAGES];
    logic             w_c  [STAGES];

    logic [STAGES-1:0] r_v;     // per-stage valid bits
    logic [STAGES-1:0] w_vin;   // valid bit presented to each stage
    logic [STAGES-1:0] w_ld;    // stage loads this cycle

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_of;

    // Operand preparation: subtraction is A + ~B + 1.
    assign w_a[0]  = A;
    assign w_b[0]  = sub ? ~B : B;
    assign w_lo[0] = '0;
    assign w_c[0]  = sub | cin;

    // Load chain from the output backwards: a stage loads when it is empty
    // or its successor loads, so empty slots absorb beats during a stall.
    always_comb begin
        logic ld;
        w_ld = '0;
        ld   = !r_v[STAGES-1] || out_ready;
        w_ld[STAGES-1] = ld;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld      = !r_v[k] || ld;
            w_ld[k] = ld;
        end
    end

    always_comb begin
        w_vin    = '0;
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k] = r_v[k-1];
        end
    end

    assign in_ready  = w_ld[0] && !rst;
    assign out_valid = r_v[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_vin[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_lo_n;
        logic             w_c_n;
        logic [SEG_W:0]   w_s0;
        logic [SEG_W:0]   w_s1;
        logic [SEG_W:0]   w_sel;

        // Each segment forms its sum for carry-in 0 and 1; the rippling
        // segment carry only drives the select.
        // NOTE: blocking assignments here are deliberate -- the carry must
        // ripple through the segment loop within one evaluation.
        always_comb begin
            w_s0   = '0;
            w_s1   = '0;
            w_sel  = '0;
            w_lo_n = w_lo[k];
            w_c_n  = w_c[k];
            for (int s = 0; s < SPS; s++) begin
                w_s0  = {1'b0, w_a[k][(k*SPS+s)*SEG_W +: SEG_W]}
                      + {1'b0, w_b[k][(k*SPS+s)*SEG_W +: SEG_W]};
                w_s1  = w_s0 + {{SEG_W{1'b0}}, 1'b1};
                w_sel = w_c_n ? w_s1 : w_s0;
                w_lo_n[(k*SPS+s)*SEG_W +: SEG_W] = w_sel[SEG_W-1:0];
                w_c_n = w_sel[SEG_W];
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_lo;
            logic             r_c;

            // NOTE: datapath registers carry no reset; the stage valid bit
            // alone decides whether their contents mean anything.
            always_ff @(posedge clk) begin
                if (w_ld[k] && w_vin[k]) begin
                    r_a  <= w_a[k];
                    r_b  <= w_b[k];
                    r_lo <= w_lo_n;
                    r_c  <= w_c_n;
                end
            end

            assign w_a[k+1]  = r_a;
            assign w_b[k+1]  = r_b;
            assign w_lo[k+1] = r_lo;
            assign w_c[k+1]  = r_c;
        end else begin : g_last
            logic [WIDTH-1:0] w_sum;
            logic             w_of;

            // Operands of equal sign producing a result of the other sign.
            assign w_of = (w_a[k][WIDTH-1] == w_b[k][WIDTH-1])
                       && (w_lo_n[WIDTH-1] != w_a[k][WIDTH-1]);

`ifdef PIPE_CSEL_ADDER_SATURATE_EN
            always_comb begin
                w_sum = w_lo_n;
                if (w_of) begin
                    w_sum = w_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign w_sum = w_lo_n;
`endif

            // Output registers change only when a valid beat lands, which
            // keeps a stalled beat stable.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_of   <= 1'b0;
                end else if (w_ld[k] && w_vin[k]) begin
                    r_sum  <= w_sum;
                    r_cout <= w_c_n;
                    r_of   <= w_of;
                end
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign of   = r_of;

endmodule

// File: tb/tb_pipe_csel_adder.sv
//
// Self-checking bench for pipe_csel_adder (default parameters). Expected
// results come from signed/unsigned integer arithmetic on the operands.

module tb_pipe_csel_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        of;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        of;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    int   acc_cyc[$];
    int   obs_cyc[$];

    always #5 clk = ~clk;

    pipe_csel_adder #(.WIDTH(WIDTH), .SEG_W(8), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a),
        .B        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .of       (of)
    );

    // Reference: exact integer arithmetic, then range checks.
    function automatic res_t model(logic [31:0] ma, logic [31:0] mb,
                                   logic mc, logic ms);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint r;
        res_t   m;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        if (ms) begin
            r      = sa - sb;
            m.cout = (ua >= ub);
        end else begin
            r      = sa + sb + longint'(mc);
            m.cout = (ua + ub + longint'(mc)) >= 64'sd4294967296;
        end
        m.sum = r[31:0];
        m.of  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef PIPE_CSEL_ADDER_SATURATE_EN
        if (m.of) m.sum = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return m;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: record handshakes at the falling edge, then move to just
    // after the next rising edge where the caller drives new inputs.
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            obs_q.push_back(res_t'({sum, cout, of}));
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        acc_cyc.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
        n_tests++; if ({cout, of} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_of: got %b want 00", {cout, of}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_0000};
        logic [31:0] vb [5] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0002, 32'h0000_FFFF, 32'hFFFF_FFFF};
        logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef PIPE_CSEL_ADDER_SATURATE_EN
        logic [31:0] es [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0};
`else
        logic [31:0] es [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
`endif
        logic        eco [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        eof [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            clear_q();
            out_ready = 1'b1;
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int t = 0; t < 10 && obs_q.size() == 0; t++) tick();
            n_tests++;
            if (obs_q.size() != 1 || acc_cyc.size() != 1) begin
                n_fail++;
                $display("FAIL directed_%0d_count: got %0d results want 1", i, obs_q.size());
            end else begin
                n_tests++;
                if (obs_cyc[0] - acc_cyc[0] != STAGES) begin
                    n_fail++;
                    $display("FAIL directed_%0d_latency: got %0d want %0d", i, obs_cyc[0] - acc_cyc[0], STAGES);
                end
                n_tests++;
                if (obs_q[0] !== res_t'({es[i], eco[i], eof[i]})) begin
                    n_fail++;
                    $display("FAIL directed_%0d: got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                             i, obs_q[0].sum, obs_q[0].cout, obs_q[0].of, es[i], eco[i], eof[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 32'(i); b = 32'h0000_FFFF; cin = i[0]; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20 && obs_q.size() < 8; t++) tick();
        n_tests++;
        if (acc_cyc.size() != 8 || obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d in / %0d out want 8 / 8", acc_cyc.size(), obs_q.size());
        end else begin
            n_tests++;
            if (obs_cyc[0] - acc_cyc[0] != STAGES) begin
                n_fail++;
                $display("FAIL b2b_latency: got %0d want %0d", obs_cyc[0] - acc_cyc[0], STAGES);
            end
            for (int i = 0; i < 8; i++) begin
                want = 32'(i) + 32'h0000_FFFF + 32'(i % 2);
                n_tests++;
                if (obs_q[i] !== res_t'({want, 1'b0, 1'b0}) || obs_cyc[i] != obs_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got sum=%h cout=%b of=%b cyc+%0d want sum=%h cout=0 of=0 cyc+%0d",
                             i, obs_q[i].sum, obs_q[i].cout, obs_q[i].of, obs_cyc[i] - obs_cyc[0], want, i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        res_t        held;
        logic        have_held;
        clear_q();
        for (int i = 0; i < 4; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
        have_held = 1'b0;
        out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
        for (int t = 0; t < 5; t++) begin
            in_valid = exp_q.size() < 4;
            a = (exp_q.size() < 4) ? pa[exp_q.size()] : $urandom;
            b = (exp_q.size() < 4) ? pb[exp_q.size()] : $urandom;
            tick();
            if (out_valid) begin
                if (!have_held) begin
                    held = res_t'({sum, cout, of});
                    have_held = 1'b1;
                end else begin
                    n_tests++;
                    if (res_t'({sum, cout, of}) !== held) begin
                        n_fail++;
                        $display("FAIL bp_hold: got %h want %h", {sum, cout, of}, held);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != STAGES) begin
            n_fail++;
            $display("FAIL bp_captured: got %0d want %0d", exp_q.size(), STAGES);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int t = 0; t < 30 && obs_q.size() < 4; t++) begin
            in_valid = exp_q.size() < 4;
            a = (exp_q.size() < 4) ? pa[exp_q.size()] : 32'h0;
            b = (exp_q.size() < 4) ? pb[exp_q.size()] : 32'h0;
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs_q[i] !== model(pa[i], pb[i], 1'b0, 1'b0)) begin
                    n_fail++;
                    $display("FAIL bp_drain_%0d: got %h want %h", i, obs_q[i], model(pa[i], pb[i], 1'b0, 1'b0));
                end
            end
        end
    endtask

    task automatic test_random();
        int bad;
        clear_q();
        bad = 0;
        for (int t = 0; t < 300; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = pick(); b = pick(); cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) tick();
        n_tests++;
        if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    if (bad < 10) $display("FAIL rand_%0d: got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                                           i, obs_q[i].sum, obs_q[i].cout, obs_q[i].of,
                                           exp_q[i].sum, exp_q[i].cout, exp_q[i].of);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        a = 32'h0000_1234; b = 32'h0000_0001; in_valid = 1'b1; tick();
        a = 32'h0000_5678; b = 32'h0000_0002; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (sum !== 32'h0) begin n_fail++; $display("FAIL midrst_sum: got %h want 0", sum); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        repeat (6) tick();
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d beats want 0", obs_q.size()); end
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 10 && obs_q.size() == 0; t++) tick();
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0] !== res_t'({32'h0, 1'b1, 1'b0})) begin
            n_fail++;
            $display("FAIL midrst_next: got %0d beats first=%h want 1 beat sum=0 cout=1 of=0",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : res_t'('x));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
